// File: rtl/edge_event_arbiter.sv
// Falling-edge event capture with round-robin arbitration over WIDTH
// sources. Each captured event stays pending until it is accepted.
// A second fall on a source that is still pending sets a sticky overflow flag.
module edge_event_arbiter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_i,
   input  logic [WIDTH-1:0] mask_i,
   input  logic             evt_ready_i,
   input  logic             ovf_clr_i,
   output logic             evt_valid_o,
   output logic [4:0]       evt_id_o,
   output logic [WIDTH-1:0] pending_o,
   output logic [WIDTH-1:0] ovf_o
);

   localparam int IDW = 5;

   typedef enum logic {IDLE, OFFER} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] pending;
   logic [WIDTH-1:0] ovf;
   logic [WIDTH-1:0] neg;
   logic [WIDTH-1:0] clr;
   logic [WIDTH-1:0] eligible;
   logic [IDW-1:0]   rr_ptr;
   logic [IDW-1:0]   winner;
   logic [IDW-1:0]   idx;
   logic             found;
   logic             accept;
   logic             load_offer;

   assign neg        = data_q & ~data_i;
   assign eligible   = pending & mask_i;
   assign accept     = (state == OFFER) && evt_ready_i;
   assign load_offer = (state == IDLE) && (|eligible);

   assign evt_valid_o = (state == OFFER);
   assign pending_o   = pending;
   assign ovf_o       = ovf;

   // One-hot clear for the source whose offer is accepted this cycle
   always_comb begin
      clr = '0;
      if (accept) clr[evt_id_o] = 1'b1;
   end

   // Round-robin search: first eligible source at or above rr_ptr, wrapping
   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = '0;
      for (int k = 0; k < WIDTH; k++) begin
         idx = rr_ptr + IDW'(k);
         if (!found && eligible[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // FSM next state: always one IDLE cycle between consecutive offers
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (|eligible)  state_nxt = OFFER;
         OFFER:   if (evt_ready_i) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Edge detect history, pending capture (set wins over accept) and sticky overflow
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_q  <= '0;
         pending <= '0;
         ovf     <= '0;
      end else begin
         data_q  <= data_i;
         pending <= (pending & ~clr) | neg;
         ovf     <= (ovf_clr_i ? '0 : ovf) | (neg & pending & ~clr);
      end
   end

   // Offered id is latched on entry to OFFER and held until accepted
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         evt_id_o <= '0;
         rr_ptr   <= '0;
      end else begin
         if (load_offer) evt_id_o <= winner;
         if (accept)     rr_ptr   <= evt_id_o + IDW'(1);
      end
   end

endmodule
